// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DEF_DIVIDEND_W = 16;
  localparam int unsigned DEF_DIVISOR_W  = 8;
  localparam int unsigned CNT_W          = $clog2(DEF_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration: trial subtract and quotient bit.
module div_restore_step #(
  parameter int unsigned DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] rem,
  input  logic                 q_msb,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] next_rem,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] trial;
  logic [DIVISOR_W:0] diff;

  // rem < divisor holds, so the MSB of the (DIVISOR_W+1)-bit difference is a clean borrow
  always_comb begin
    trial    = {rem, q_msb};
    diff     = trial - {1'b0, divisor};
    q_bit    = ~diff[DIVISOR_W];
    next_rem = q_bit ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/divider16by8_seq.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
module divider16by8_seq
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CW = $clog2(DIVIDEND_W);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic                  dbz_q, dbz_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q_bit;

  div_restore_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem      (rem_q),
    .q_msb    (q_q[DIVIDEND_W-1]),
    .divisor  (dvsr_q),
    .next_rem (step_rem),
    .q_bit    (step_q_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (divisor != '0) begin
            q_d     = dividend;
            dvsr_d  = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            // Divide-by-zero bypasses iteration with a fixed result
            q_d     = '1;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        q_d   = {q_q[DIVIDEND_W-2:0], step_q_bit};
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIVIDEND_W - 1)) begin
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = q_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider16by8_seq.sv
// Directed and randomized checks for divider16by8_seq against hand-computed results.
module tb_divider16by8_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  divider16by8_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present one operation from IDLE; return latency in edges from the accept edge to out_valid
  task automatic start_op(input logic [15:0] a, input logic [7:0] b, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ir_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                          input int elat);
    int lat;
    start_op(a, b, lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    check({tag, "_ir_busy"}, 32'(in_ready), 32'd0);
    finish_op(tag);
  endtask

  initial begin
    int lat;
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [15:0] eq;
    logic [7:0]  er;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
    directed("d65535_255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 17);
    directed("d65535_1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 17);
    directed("d5_0", 16'd5, 8'd0, 16'hFFFF, 8'd5, 1'b1, 1);
    directed("d3_200", 16'd3, 8'd200, 16'd0, 8'd3, 1'b0, 17);
    directed("d0_9", 16'd0, 8'd9, 16'd0, 8'd0, 1'b0, 17);
    directed("d258_0", 16'd258, 8'd0, 16'hFFFF, 8'd2, 1'b1, 1);

    // Back-pressure: result must hold and new requests be ignored while out_ready is low
    start_op(16'd50000, 8'd123, lat);
    check("bp_lat", 32'(lat), 32'd17);
    dividend = 16'd77;
    divisor  = 8'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ov", 32'(out_valid), 32'd1);
      check("bp_hold_ir", 32'(in_ready), 32'd0);
    end
    check("bp_q", 32'(quotient), 32'd406);
    check("bp_r", 32'(remainder), 32'd62);
    in_valid = 1'b0;
    finish_op("bp");
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_no_accept_ir", 32'(in_ready), 32'd1);
      check("bp_no_accept_q", 32'(quotient), 32'd406);
    end

    // Reset in the middle of iteration discards the operation
    dividend = 16'd1000;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ir", 32'(in_ready), 32'd1);
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_q", 32'(quotient), 32'd0);
    check("mid_rst_r", 32'(remainder), 32'd0);
    check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    directed("d100_10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 17);

    // Randomized operations with random idle and back-pressure gaps
    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if (rb == 8'd0) begin
        eq = 16'hFFFF;
        er = ra[7:0];
      end else begin
        eq = ra / 16'(rb);
        er = 8'(ra % 16'(rb));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      start_op(ra, rb, lat);
      check("rnd_lat", 32'(lat), (rb == 8'd0) ? 32'd1 : 32'd17);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check("rnd_q", 32'(quotient), 32'(eq));
      check("rnd_r", 32'(remainder), 32'(er));
      check("rnd_dbz", 32'(div_by_zero), 32'(rb == 8'd0));
      if (rb != 8'd0) check("rnd_inv", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
      finish_op("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
